// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: per-gate request FIFOs, exit-priority dispatcher,
// and an IDLE/OPEN/GUARD barrier sequencer per gate with registered event outputs.

module parking_gate_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_tag,
  input  logic i_pop,
  output logic o_head_c,
  output logic o_empty_c,
  output logic o_drop_c,
  output logic o_full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic [CW-1:0]    w_count_nxt;

  // Fullness is judged on the start-of-cycle state, so a same-cycle pop never frees a slot.
  assign w_push      = i_push && !o_full;
  assign o_drop_c    = i_push && o_full;
  assign o_empty_c   = (r_count == '0);
  assign o_head_c    = r_mem[r_rd];
  assign w_count_nxt = r_count + CW'(w_push) - CW'(i_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      o_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_tag;
        r_wr        <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_count <= w_count_nxt;
      o_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end
endmodule

module parking_gate_fsm #(
  parameter int unsigned GATE_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_idle_c,
  output logic o_open
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;

  assign o_idle_c = (r_state == S_IDLE);

  // Barrier drive lags the state by one edge so it rises together with the event pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      o_open  <= 1'b0;
    end else begin
      o_open <= (r_state == S_OPEN);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_OPEN;
            r_cnt   <= 8'(GATE_HOLD - 1);
          end
        end
        S_OPEN: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_GUARD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_GUARD: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

module parking_gate_ctrl #(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned GATE_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       entry_uni,
  input  logic       exit_req,
  input  logic       exit_uni,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_rejected,
  output logic       entry_q_full,
  output logic       exit_q_full,
  output logic [7:0] drop_count
);
  logic       w_en_head, w_en_empty, w_en_drop, w_en_idle;
  logic       w_ex_head, w_ex_empty, w_ex_drop, w_ex_idle;
  logic       w_pop_exit, w_pop_entry, w_space, w_admit;
  logic [8:0] w_drop_sum;

  logic r_ex_pend, r_ex_tag, r_en_pend, r_en_tag, r_rej_pend;

  parking_gate_fifo #(.DEPTH(QDEPTH)) u_entry_q (
    .clk(clk), .rst(rst), .i_push(entry_req), .i_tag(entry_uni), .i_pop(w_pop_entry),
    .o_head_c(w_en_head), .o_empty_c(w_en_empty), .o_drop_c(w_en_drop), .o_full(entry_q_full)
  );

  parking_gate_fifo #(.DEPTH(QDEPTH)) u_exit_q (
    .clk(clk), .rst(rst), .i_push(exit_req), .i_tag(exit_uni), .i_pop(w_pop_exit),
    .o_head_c(w_ex_head), .o_empty_c(w_ex_empty), .o_drop_c(w_ex_drop), .o_full(exit_q_full)
  );

  parking_gate_fsm #(.GATE_HOLD(GATE_HOLD)) u_entry_gate (
    .clk(clk), .rst(rst), .i_start(w_admit), .o_idle_c(w_en_idle), .o_open(entry_gate_open)
  );

  parking_gate_fsm #(.GATE_HOLD(GATE_HOLD)) u_exit_gate (
    .clk(clk), .rst(rst), .i_start(w_pop_exit), .o_idle_c(w_ex_idle), .o_open(exit_gate_open)
  );

  // One pop per cycle, exit first; entry is admitted only if its class has space.
  assign w_pop_exit  = !w_ex_empty && w_ex_idle;
  assign w_pop_entry = !w_pop_exit && !w_en_empty && w_en_idle;
  assign w_space     = w_en_head ? uni_is_vacated_space : is_vacated_space;
  assign w_admit     = w_pop_entry && w_space;
  assign w_drop_sum  = 9'(drop_count) + 9'(w_en_drop) + 9'(w_ex_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_pend          <= 1'b0;
      r_ex_tag           <= 1'b0;
      r_en_pend          <= 1'b0;
      r_en_tag           <= 1'b0;
      r_rej_pend         <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      entry_rejected     <= 1'b0;
      drop_count         <= '0;
    end else begin
      r_ex_pend          <= w_pop_exit;
      r_ex_tag           <= w_pop_exit && w_ex_head;
      r_en_pend          <= w_admit;
      r_en_tag           <= w_admit && w_en_head;
      r_rej_pend         <= w_pop_entry && !w_space;
      car_exited         <= r_ex_pend;
      is_uni_car_exited  <= r_ex_tag;
      car_entered        <= r_en_pend;
      is_uni_car_entered <= r_en_tag;
      entry_rejected     <= r_rej_pend;
      drop_count         <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
    end
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: a per-cycle vector table plus
// hand-written sequences for queue overflow, reset mid-operation and drop saturation.

module tb_parking_gate_ctrl;
  localparam int unsigned GH = 8;

  logic       clk = 1'b0;
  logic       rst, entry_req, entry_uni, exit_req, exit_uni, uni_vac, vac;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic       entry_gate_open, exit_gate_open, entry_rejected, entry_q_full, exit_q_full;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  parking_gate_ctrl #(.QDEPTH(4), .GATE_HOLD(GH)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .entry_uni(entry_uni),
    .exit_req(exit_req), .exit_uni(exit_uni),
    .uni_is_vacated_space(uni_vac), .is_vacated_space(vac),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .entry_rejected(entry_rejected), .entry_q_full(entry_q_full),
    .exit_q_full(exit_q_full), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ereq, euni, xreq, xuni, uvac, vac;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Packed view: ce,ue,cx,ux,eo,xo,rej,eqf,xqf
  function automatic logic [8:0] outs();
    return {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
            entry_gate_open, exit_gate_open, entry_rejected, entry_q_full, exit_q_full};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; entry_req = 1'b0; entry_uni = 1'b0; exit_req = 1'b0; exit_uni = 1'b0;
    uni_vac = 1'b1; vac = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic r, er, eu, xr, xu, uv, v, input logic [8:0] e);
    vec_t t;
    t.rst = r; t.ereq = er; t.euni = eu; t.xreq = xr; t.xuni = xu; t.uvac = uv; t.vac = v;
    t.exp = e;
    tbl.push_back(t);
  endtask

  // Invariants on every cycle: never two events at once, tags only with their events.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((car_entered && car_exited) || (is_uni_car_entered && !car_entered) ||
          (is_uni_car_exited && !car_exited)) begin
        errors++;
        $display("FAIL invariant: ce=%b ue=%b cx=%b ux=%b required no coincident event and no orphan tag",
                 car_entered, is_uni_car_entered, car_exited, is_uni_car_exited);
      end
    end
  end

  initial begin
    int   times[$];
    logic wrapped;
    logic leaked;
    logic [7:0] prev;

    idle_inputs();

    add(1, 0,0,0,0,1,1, 9'b000000000);
    add(0, 1,0,0,0,1,1, 9'b000000000);
    add(0, 0,0,0,0,1,1, 9'b000000000);
    add(0, 0,0,0,0,1,1, 9'b100010000);
    for (int i = 0; i < 7; i++) add(0, 0,0,0,0,1,1, 9'b000010000);
    add(0, 0,0,0,0,1,1, 9'b000000000);
    add(0, 1,1,0,0,0,1, 9'b000000000);
    add(0, 0,0,0,0,0,1, 9'b000000000);
    add(0, 0,0,0,0,0,1, 9'b000000100);
    add(0, 0,0,0,0,1,1, 9'b000000000);
    add(0, 1,1,1,1,1,1, 9'b000000000);
    add(0, 0,0,0,0,1,1, 9'b000000000);
    add(0, 0,0,0,0,1,1, 9'b001101000);
    add(0, 0,0,0,0,1,1, 9'b110011000);
    add(0, 0,0,0,0,1,1, 9'b000011000);

    #2;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; entry_req = tbl[i].ereq; entry_uni = tbl[i].euni;
      exit_req = tbl[i].xreq; exit_uni = tbl[i].xuni; uni_vac = tbl[i].uvac; vac = tbl[i].vac;
      tick();
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_drop", i), 32'(drop_count), 32'd0);
    end

    // Six back-to-back entries into a 4-deep queue: one drop, events GH+2 apart.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      entry_req = (i < 6);
      tick();
      if (car_entered) times.push_back(i);
      if (i == 4) begin
        chk("ovf_full_after_5th", 32'(entry_q_full), 32'd1);
        chk("ovf_drop_after_5th", 32'(drop_count), 32'd0);
      end
      if (i == 5) chk("ovf_drop_after_6th", 32'(drop_count), 32'd1);
    end
    chk("ovf_event_count", 32'(times.size()), 32'd5);
    foreach (times[k]) chk($sformatf("ovf_event%0d_cycle", k), 32'(times[k]), 32'(2 + k * (GH + 2)));
    chk("ovf_drop_final", 32'(drop_count), 32'd1);

    // Reset during the 4th open cycle with two vehicles still queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      entry_req = 1'b1;
      tick();
    end
    entry_req = 1'b0;
    chk("rst_gate_open_before", 32'(entry_gate_open), 32'd1);
    tick(); tick(); tick();
    chk("rst_gate_open_4th", 32'(entry_gate_open), 32'd1);
    rst = 1'b1; entry_req = 1'b1; exit_req = 1'b1;
    tick();
    chk("rst_outs_cleared", 32'(outs()), 32'd0);
    chk("rst_drop_cleared", 32'(drop_count), 32'd0);
    idle_inputs();
    leaked = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (outs() != 9'd0) leaked = 1'b1;
    end
    chk("rst_no_later_activity", 32'(leaked), 32'd0);

    // Simultaneous drops on both queues add two.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      entry_req = 1'b1; exit_req = 1'b1;
      tick();
      if (i == 4) chk("dual_both_full", 32'({entry_q_full, exit_q_full}), 32'h3);
    end
    idle_inputs();
    chk("dual_drop_two", 32'(drop_count), 32'd2);

    // A long exit burst saturates the drop counter without wrapping.
    do_reset();
    wrapped = 1'b0;
    prev = 8'd0;
    for (int i = 0; i < 300; i++) begin
      exit_req = 1'b1;
      tick();
      if (drop_count < prev) wrapped = 1'b1;
      prev = drop_count;
    end
    idle_inputs();
    tick();
    chk("sat_no_wrap", 32'(wrapped), 32'd0);
    chk("sat_drop_255", 32'(drop_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 The block SHALL have parameter QDEPTH, default 4, meaning the entries per gate queue (power of two, 2..16).
REQ-002 The block SHALL have parameter GATE_HOLD, default 8, meaning the cycles a barrier stays open (1..255).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 entry_req  in  1  entry loop detects a vehicle (1-cycle pulse per vehicle).
REQ-006 entry_uni  in  1  tag of entering vehicle, sampled with entry_req: 1 = university, 0 = public.
REQ-007 exit_req  in  1  exit loop detects a vehicle (1-cycle pulse).
REQ-008 exit_uni  in  1  tag of exiting vehicle, sampled with exit_req.
REQ-009 uni_is_vacated_space  in  1  downstream counter: university space available.
REQ-010 is_vacated_space  in  1  downstream counter: public space available.
REQ-011 car_entered, is_uni_car_entered  out  1,1  registered entry event to the parking counter.
REQ-012 car_exited, is_uni_car_exited  out  1,1  registered exit event to the parking counter.
REQ-013 entry_gate_open, exit_gate_open  out  1,1  barrier drive, 1 = open.
REQ-014 entry_rejected  out  1  1-cycle pulse when an entry is refused for lack of space.
REQ-015 entry_q_full, exit_q_full  out  1,1  queue holds QDEPTH entries.
REQ-016 drop_count  out  8  requests lost to a full queue, saturating.

Function
REQ-017 Each gate SHALL own a FIFO of QDEPTH 1-bit tags; a request SHALL push on the edge it is sampled if the FIFO is not full at the start of that cycle.
- A full FIFO SHALL reject the push even when it is popped in the same cycle.
- Simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-018 A request arriving while its FIFO is full SHALL be dropped, and drop_count SHALL increment, holding at 255.
- Simultaneous entry and exit drops SHALL add 2, saturating.
REQ-019 Each gate SHALL run the FSM IDLE -> OPEN -> GUARD -> IDLE.
- OPEN: gate_open = 1 for exactly GATE_HOLD cycles.
- GUARD: gate_open = 0 for 1 cycle.
REQ-020 Dispatch SHALL issue at most one downstream event per cycle; car_entered and car_exited SHALL never be high together.
REQ-021 Exit SHALL have priority: if the exit FIFO is non-empty and the exit FSM is IDLE, the dispatcher SHALL pop it.
- Next cycle: car_exited = 1 for one cycle, is_uni_car_exited = head tag, exit FSM enters OPEN.
REQ-022 Otherwise, if the entry FIFO is non-empty and the entry FSM is IDLE, the dispatcher SHALL pop the head and test the space flag for its tag (uni -> uni_is_vacated_space, public -> is_vacated_space), sampled in the decision cycle.
- Flag 1: next cycle car_entered = 1 and is_uni_car_entered = tag for one cycle; entry FSM enters OPEN.
- Flag 0: next cycle entry_rejected = 1 for one cycle; no car_entered; FSM stays IDLE.
REQ-023 Latency from request sample edge to event pulse SHALL be 2 cycles when the queue is empty and the gate is IDLE.
REQ-024 entry_gate_open / exit_gate_open SHALL rise on the same edge as the corresponding event pulse.
REQ-025 The next event through the same gate SHALL be no earlier than GATE_HOLD+2 cycles after the previous one.
REQ-026 is_uni_car_* SHALL be 0 whenever the corresponding event bit is 0.
REQ-027 entry_q_full / exit_q_full SHALL be registered and reflect the post-edge FIFO count.
REQ-028 The block SHALL NOT check capacity itself; the downstream counter re-checks and ignores excess events.

Reset
REQ-029 While rst = 1 at a rising edge, the block SHALL empty both FIFOs, set both FSMs to IDLE, and clear drop_count.
- All outputs SHALL be 0 after that edge.
REQ-030 Reset mid-operation SHALL close an open barrier on the next edge and discard queued vehicles; request inputs SHALL be ignored during reset.

Verification
REQ-031 A bench SHALL cover these directed scenarios:
- Public entry, is_vacated_space = 1, GATE_HOLD = 8 -> car_entered = 1 and is_uni_car_entered = 0 for 1 cycle, 2 cycles after req; entry_gate_open high 8 cycles, then low.
- entry_req and exit_req in the same cycle, both FIFOs empty -> car_exited pulse at +2, car_entered pulse at +3, never coincident.
- Uni entry with uni_is_vacated_space = 0 -> entry_rejected pulse at +2; car_entered stays 0; entry_gate_open stays 0.
- 6 entry_req on consecutive cycles, QDEPTH = 4, flags = 1 -> 5 accepted, 1 dropped; drop_count = 1; entry_q_full = 1 after the 5th request edge; car_entered pulses spaced GATE_HOLD+2 apart.
- rst asserted during the 4th cycle of entry_gate_open with 2 queued -> after that edge, gate = 0, both FIFOs empty, all outputs 0; no further events.
- 300 exit_req pulses with exit gate held busy -> drop_count saturates at 255 and does not wrap.
